// File: rtl/exec_pkg.sv
// Shared definitions for the arithmetic execution port.
//   - opcode, function-type and status-bit encodings
//   - multiplier FSM state encoding
//   - writeback bundle struct and an opcode-class helper
package exec_pkg;

  localparam int XLEN  = 16;
  localparam int OPC_W = 7;
  localparam int REG_W = 5;
  localparam int FT_W  = 2;
  localparam int ST_W  = 2;

  localparam logic [OPC_W-1:0] OP_NOP = 7'd0;
  localparam logic [OPC_W-1:0] OP_ADD = 7'd1;
  localparam logic [OPC_W-1:0] OP_SUB = 7'd2;
  localparam logic [OPC_W-1:0] OP_AND = 7'd3;
  localparam logic [OPC_W-1:0] OP_OR  = 7'd4;
  localparam logic [OPC_W-1:0] OP_XOR = 7'd5;
  localparam logic [OPC_W-1:0] OP_SHL = 7'd6;
  localparam logic [OPC_W-1:0] OP_SHR = 7'd7;
  localparam logic [OPC_W-1:0] OP_MUL = 7'd8;

  localparam logic [FT_W-1:0] FT_ARITH = 2'b00;
  localparam logic [FT_W-1:0] FT_LS    = 2'b01;

  localparam int ST_CARRY = 0;
  localparam int ST_ZERO  = 1;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_MUL  = 1'b1
  } mul_state_e;

  // Registered writeback bundle returned to the register file.
  typedef struct packed {
    logic             wb;
    logic [REG_W-1:0] addr;
    logic [XLEN-1:0]  val;
    logic [ST_W-1:0]  st;
  } wb_bundle_t;

  // Ops completing in a single cycle with a computed result.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clk_i/rst_i : clock, synchronous active-high reset
//   start_i     : load operands and begin (ignored while busy)
//   abort_i     : drop the in-flight product, return to idle, no done
//   mcand_i     : multiplicand, mplr_i : multiplier
//   busy_o      : iterating
//   done_o      : 1-cycle pulse on the final iteration; prod_o valid then
//   prod_o      : full 2W-bit product (combinational, includes last add)
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [W-1:0]   mplr_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [2*W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]       mplr_q, mplr_d;
  logic [2*W-1:0]     acc_nxt;
  logic               last;

  assign last    = (count_q == CNT_W'(N-1));
  assign acc_nxt = acc_q + (mplr_q[0] ? mcand_q : '0);

  // State register plus datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MS_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    case (state_q)
      MS_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = MS_MUL;
          count_d = '0;
          acc_d   = '0;
          mcand_d = {{W{1'b0}}, mcand_i};
          mplr_d  = mplr_i;
        end
      end
      MS_MUL: begin
        if (abort_i) begin
          state_d = MS_IDLE;
          count_d = '0;
          acc_d   = '0;
          mcand_d = '0;
          mplr_d  = '0;
        end else begin
          acc_d   = acc_nxt;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          count_d = count_q + 1'b1;
          if (last) state_d = MS_IDLE;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // Outputs. done is suppressed when the same cycle is aborted.
  always_comb begin
    busy_o = (state_q == MS_MUL);
    done_o = (state_q == MS_MUL) && last && !abort_i;
    prod_o = acc_nxt;
  end

endmodule

// File: rtl/exec_arith_port.sv
// Arithmetic execution port, downstream of register read.
// Takes one issue slot per cycle, returns a registered writeback bundle
// {wb_o, wbAddr_o, wbVal_o, operationStatus_o={zero,carry}}.
// Single-cycle ALU ops write back one cycle after acceptance.
// Optional macro EXEC_MUL_EN: builds the iterative multiplier (OP_MUL,
// 17-cycle latency, busy_o stalls issue). Without it OP_MUL is illegal
// and busy_o is tied low.
// Ports:
//   clock_i, reset_i (sync, active-high)
//   enable_i, wb_i, opCode_i, regAddr_i, primOperand_i, secOperand_i,
//   functionType_i, operationStatus_i, flush_i      : issue slot
//   busy_o                                          : stall to issue
//   wb_o, wbAddr_o, wbVal_o, operationStatus_o      : writeback bundle
module exec_arith_port
  import exec_pkg::*;
#(
  parameter int DATA_W     = XLEN,
  parameter int MUL_CYCLES = XLEN
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              wb_i,
  input  logic [OPC_W-1:0]  opCode_i,
  input  logic [REG_W-1:0]  regAddr_i,
  input  logic [DATA_W-1:0] primOperand_i,
  input  logic [DATA_W-1:0] secOperand_i,
  input  logic [FT_W-1:0]   functionType_i,
  input  logic [ST_W-1:0]   operationStatus_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              wb_o,
  output logic [REG_W-1:0]  wbAddr_o,
  output logic [DATA_W-1:0] wbVal_o,
  output logic [ST_W-1:0]   operationStatus_o
);

  localparam int SH_W = $clog2(DATA_W);

  wb_bundle_t          out_q, out_d;
  logic                accept;
  logic [DATA_W:0]     sum_x, dif_x;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  logic                mul_wb_q;
  logic [REG_W-1:0]    mul_addr_q;

  // busy_o is registered inside the multiplier, so no comb loop here.
  assign accept = enable_i && !busy_o && !flush_i && (functionType_i == FT_ARITH);

  always_comb begin
    sum_x     = {1'b0, primOperand_i} + {1'b0, secOperand_i};
    dif_x     = {1'b0, primOperand_i} - {1'b0, secOperand_i};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opCode_i)
      OP_ADD: begin alu_res = sum_x[DATA_W-1:0]; alu_carry = sum_x[DATA_W]; end
      // Top bit of the widened difference is the unsigned borrow.
      OP_SUB: begin alu_res = dif_x[DATA_W-1:0]; alu_carry = dif_x[DATA_W]; end
      OP_AND: alu_res = primOperand_i & secOperand_i;
      OP_OR:  alu_res = primOperand_i | secOperand_i;
      OP_XOR: alu_res = primOperand_i ^ secOperand_i;
      OP_SHL: alu_res = primOperand_i << secOperand_i[SH_W-1:0];
      OP_SHR: alu_res = primOperand_i >> secOperand_i[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic             mul_start;
  logic             mul_wb_d;
  logic [REG_W-1:0] mul_addr_d;

  assign mul_start = accept && (opCode_i == OP_MUL);

  // Destination and writeback flag travel alongside the iteration.
  always_comb begin
    mul_wb_d   = mul_wb_q;
    mul_addr_d = mul_addr_q;
    if (mul_start) begin
      mul_wb_d   = wb_i;
      mul_addr_d = regAddr_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mul_wb_q   <= 1'b0;
      mul_addr_q <= '0;
    end else begin
      mul_wb_q   <= mul_wb_d;
      mul_addr_q <= mul_addr_d;
    end
  end

  exec_mul_iter #(
    .W (DATA_W),
    .N (MUL_CYCLES)
  ) u_mul (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .start_i (mul_start),
    .abort_i (flush_i),
    .mcand_i (primOperand_i),
    .mplr_i  (secOperand_i),
    .busy_o  (busy_o),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`else
  assign busy_o     = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_prod   = '0;
  assign mul_wb_q   = 1'b0;
  assign mul_addr_q = '0;
`endif

  // Writeback bundle: wb is a pulse, everything else holds unless updated.
  // mul_done and accept are exclusive since accept needs !busy_o.
  always_comb begin
    out_d    = out_q;
    out_d.wb = 1'b0;
    if (mul_done) begin
      out_d.wb           = mul_wb_q;
      out_d.addr         = mul_addr_q;
      out_d.val          = mul_prod[DATA_W-1:0];
      out_d.st[ST_CARRY] = |mul_prod[2*DATA_W-1:DATA_W];
      out_d.st[ST_ZERO]  = (mul_prod[DATA_W-1:0] == '0);
    end else if (accept) begin
      if (is_alu_op(opCode_i)) begin
        out_d.wb           = wb_i;
        out_d.addr         = regAddr_i;
        out_d.val          = alu_res;
        out_d.st[ST_CARRY] = alu_carry;
        out_d.st[ST_ZERO]  = (alu_res == '0);
      end else if (opCode_i == OP_NOP) begin
        out_d.st = operationStatus_i;
      end
      // Illegal opcodes (and OP_MUL start) leave the bundle untouched.
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) out_q <= '0;
    else         out_q <= out_d;
  end

  assign wb_o              = out_q.wb;
  assign wbAddr_o          = out_q.addr;
  assign wbVal_o           = out_q.val;
  assign operationStatus_o = out_q.st;

endmodule

// File: tb/tb_exec_arith_port.sv
module tb_exec_arith_port;
  import exec_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_i, enable_i, wb_i, flush_i;
  logic [6:0]  opCode_i;
  logic [4:0]  regAddr_i;
  logic [15:0] primOperand_i, secOperand_i;
  logic [1:0]  functionType_i, operationStatus_i;
  logic        busy_o, wb_o;
  logic [4:0]  wbAddr_o;
  logic [15:0] wbVal_o;
  logic [1:0]  operationStatus_o;

  int errors = 0;
  int checks = 0;

  exec_arith_port dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .enable_i          (enable_i),
    .wb_i              (wb_i),
    .opCode_i          (opCode_i),
    .regAddr_i         (regAddr_i),
    .primOperand_i     (primOperand_i),
    .secOperand_i      (secOperand_i),
    .functionType_i    (functionType_i),
    .operationStatus_i (operationStatus_i),
    .flush_i           (flush_i),
    .busy_o            (busy_o),
    .wb_o              (wb_o),
    .wbAddr_o          (wbAddr_o),
    .wbVal_o           (wbVal_o),
    .operationStatus_o (operationStatus_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [4:0] rd,
                       input logic [15:0] a, input logic [15:0] b);
    enable_i = 1'b1; wb_i = 1'b1; opCode_i = op; regAddr_i = rd;
    primOperand_i = a; secOperand_i = b; functionType_i = FT_ARITH;
  endtask

  task automatic chk_wb(input string tag, input logic w, input logic [4:0] a,
                        input logic [15:0] v, input logic [1:0] s);
    chk({tag, ".wb"},   32'(wb_o), 32'(w));
    chk({tag, ".addr"}, 32'(wbAddr_o), 32'(a));
    chk({tag, ".val"},  32'(wbVal_o), 32'(v));
    chk({tag, ".st"},   32'(operationStatus_o), 32'(s));
  endtask

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; wb_i = 1'b0; flush_i = 1'b0;
    opCode_i = '0; regAddr_i = '0; primOperand_i = '0; secOperand_i = '0;
    functionType_i = FT_ARITH; operationStatus_i = '0;
    tick(); tick();
    reset_i = 1'b0;
    chk_wb("reset", 1'b0, 5'd0, 16'h0000, 2'b00);
    chk("reset.busy", 32'(busy_o), 32'd0);

    // ADD overflow: 0xFFFF + 1 -> 0, carry and zero set
    issue(OP_ADD, 5'd3, 16'hFFFF, 16'h0001); tick(); enable_i = 1'b0;
    chk_wb("add", 1'b1, 5'd3, 16'h0000, 2'b11);
    tick();
    chk_wb("add_pulse", 1'b0, 5'd3, 16'h0000, 2'b11);

    issue(OP_SUB, 5'd4, 16'h0005, 16'h0007); tick(); enable_i = 1'b0;
    chk_wb("sub", 1'b1, 5'd4, 16'hFFFE, 2'b01);

    issue(OP_SHL, 5'd5, 16'h0001, 16'h0013); tick(); enable_i = 1'b0;
    chk_wb("shl", 1'b1, 5'd5, 16'h0008, 2'b00);

    issue(OP_AND, 5'd6, 16'hF0F0, 16'h0F0F); tick(); enable_i = 1'b0;
    chk_wb("and", 1'b1, 5'd6, 16'h0000, 2'b10);

    issue(OP_OR, 5'd7, 16'h1200, 16'h0034); tick(); enable_i = 1'b0;
    chk_wb("or", 1'b1, 5'd7, 16'h1234, 2'b00);

    issue(OP_XOR, 5'd8, 16'hA5A5, 16'hFFFF); tick(); enable_i = 1'b0;
    chk_wb("xor", 1'b1, 5'd8, 16'h5A5A, 2'b00);

    issue(OP_SHR, 5'd9, 16'h8000, 16'h000F); tick(); enable_i = 1'b0;
    chk_wb("shr", 1'b1, 5'd9, 16'h0001, 2'b00);

    // wb_i=0: result still registered, no strobe
    issue(OP_ADD, 5'd10, 16'h0002, 16'h0003); wb_i = 1'b0; tick(); enable_i = 1'b0;
    chk_wb("add_nowb", 1'b0, 5'd10, 16'h0005, 2'b00);

    // Load/store class slot is ignored
    issue(OP_ADD, 5'd11, 16'h0001, 16'h0001); functionType_i = FT_LS; tick(); enable_i = 1'b0;
    functionType_i = FT_ARITH;
    chk_wb("ft_ls", 1'b0, 5'd10, 16'h0005, 2'b00);

    // NOP: no strobe, status follows the incoming status
    issue(OP_NOP, 5'd10, 16'h1111, 16'h2222); operationStatus_i = 2'b10; tick(); enable_i = 1'b0;
    chk_wb("nop", 1'b0, 5'd10, 16'h0005, 2'b10);

    // Illegal opcode holds everything
    issue(7'h7F, 5'd12, 16'h0001, 16'h0001); operationStatus_i = 2'b01; tick(); enable_i = 1'b0;
    chk_wb("illegal", 1'b0, 5'd10, 16'h0005, 2'b10);

    // Flush concurrent with enable drops the slot
    issue(OP_ADD, 5'd13, 16'h0004, 16'h0004); flush_i = 1'b1; tick(); enable_i = 1'b0; flush_i = 1'b0;
    chk_wb("flush_drop", 1'b0, 5'd10, 16'h0005, 2'b10);

    // Op accepted the cycle before a flush still writes back
    issue(OP_ADD, 5'd14, 16'h0004, 16'h0004); tick(); enable_i = 1'b0; flush_i = 1'b1;
    chk_wb("flush_after", 1'b1, 5'd14, 16'h0008, 2'b00);
    tick(); flush_i = 1'b0;
    chk("flush_after.next_wb", 32'(wb_o), 32'd0);

`ifdef EXEC_MUL_EN
    // 0x100 * 0x100 = 0x10000: low half 0, carry and zero set
    issue(OP_MUL, 5'd7, 16'h0100, 16'h0100); tick(); enable_i = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("mul_busy%0d", i), 32'(busy_o), 32'd1);
      chk($sformatf("mul_nowb%0d", i), 32'(wb_o), 32'd0);
      if (i == 5) issue(OP_ADD, 5'd9, 16'h0001, 16'h0001);
      else        enable_i = 1'b0;
      tick();
    end
    chk("mul.busy_fall", 32'(busy_o), 32'd0);
    chk_wb("mul", 1'b1, 5'd7, 16'h0000, 2'b11);
    issue(OP_ADD, 5'd8, 16'h0002, 16'h0003); tick(); enable_i = 1'b0;
    chk_wb("add_after_mul", 1'b1, 5'd8, 16'h0005, 2'b00);

    // Flush mid-multiply kills it
    issue(OP_MUL, 5'd10, 16'h0003, 16'h0005); tick(); enable_i = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    chk("mulflush.busy", 32'(busy_o), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (wb_o) seen++;
        tick();
      end
      chk("mulflush.no_wb", 32'(seen), 32'd0);
    end

    // Follow-up multiply completes with 0x000F after 17 cycles
    issue(OP_MUL, 5'd10, 16'h0003, 16'h0005); tick(); enable_i = 1'b0;
    begin
      int cyc = 1;
      while (!wb_o && cyc < 40) begin tick(); cyc++; end
      chk("mul2.latency", 32'(cyc), 32'd17);
      chk_wb("mul2", 1'b1, 5'd10, 16'h000F, 2'b00);
    end

    // Reset mid-multiply aborts everything
    issue(OP_MUL, 5'd11, 16'h0003, 16'h0005); tick(); enable_i = 1'b0;
    tick(); tick(); tick();
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    chk_wb("mulrst", 1'b0, 5'd0, 16'h0000, 2'b00);
    chk("mulrst.busy", 32'(busy_o), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (wb_o) seen++;
        tick();
      end
      chk("mulrst.no_wb", 32'(seen), 32'd0);
    end
`else
    // Without the multiplier OP_MUL is illegal
    issue(OP_MUL, 5'd7, 16'h0100, 16'h0100); tick(); enable_i = 1'b0;
    chk_wb("mul_off", 1'b0, 5'd14, 16'h0008, 2'b00);
    chk("mul_off.busy", 32'(busy_o), 32'd0);
    tick();
    chk("mul_off.busy2", 32'(busy_o), 32'd0);
    chk("mul_off.wb2", 32'(wb_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_arith_port.md
Name: exec_arith_port

Overview:
- Arithmetic execution port directly downstream of the register-read stage.
- Consumes one resolved issue slot per cycle: enable, writeback flag, opcode, destination register, two 16-bit operands, function type and incoming status.
- Produces the arithmetic writeback bundle (enable, address, value, status) that returns to the register file.
- Single-cycle ALU ops complete in 1 cycle. Multiply is iterative shift-add, with a busy/stall indication back to issue.

Parameters:
- DATA_W, 16, operand/result width.
- MUL_CYCLES, 16, iterations of the shift-add multiplier (one per multiplier bit; must equal DATA_W).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  issue slot valid.
- wb_i  in  1  instruction requests register writeback.
- opCode_i  in  7  operation code.
- regAddr_i  in  5  destination register.
- primOperand_i  in  16  resolved primary operand.
- secOperand_i  in  16  resolved secondary operand.
- functionType_i  in  2  unit class; this port executes FT_ARITH only.
- operationStatus_i  in  2  status read with operands; passed to NOP.
- flush_i  in  1  kill in-flight and incoming work.
- busy_o  out  1  multiplier occupied; issue must hold/stall.
- wb_o  out  1  writeback strobe, 1-cycle pulse.
- wbAddr_o  out  5  writeback register.
- wbVal_o  out  16  writeback value.
- operationStatus_o  out  2  {zero, carry}, valid with wb_o.

Behaviour:
- Reset: wb_o=0, busy_o=0, wbAddr_o=0, wbVal_o=0, operationStatus_o=0, FSM=IDLE, multiplier registers cleared.
- Accept condition: enable_i && !busy_o && !flush_i && functionType_i==FT_ARITH. Otherwise the slot is ignored and wb_o=0 next cycle.
- Single-cycle ops, latency 1. Result is registered on the accepting edge. wb_o = wb_i on the next cycle. wbAddr_o=regAddr_i.
  - OP_ADD: 17-bit sum; carry=bit16.
  - OP_SUB: prim-sec mod 2^16; carry=borrow (prim<sec unsigned).
  - OP_AND, OP_OR, OP_XOR: carry=0.
  - OP_SHL, OP_SHR: logical shift by sec[3:0]; carry=0.
  - OP_NOP: wb_o forced 0; operationStatus_o=operationStatus_i.
- zero = (result[15:0]==0) for all ops except NOP.
- Illegal opcode: wb_o=0; outputs other than wb_o hold previous values.
- wbAddr_o/wbVal_o/operationStatus_o hold their values when wb_o=0.
- FSM:
  - IDLE: accepting OP_MUL -> MUL. Latch operands, dest and wb flag; count=0; busy_o=1 from the next cycle.
  - MUL: each cycle, if multiplier LSB then acc+=multiplicand (32-bit acc); shift both; count++.
  - When count==MUL_CYCLES-1: next cycle wb_o=latched wb flag, wbVal_o=acc[15:0], carry=|acc[31:16], zero on the low 16 bits. busy_o=0 that same cycle; FSM returns to IDLE.
  - Total latency 17 cycles from accept to wb_o.
  - New issue is accepted on the cycle busy_o falls.
- Flush:
  - In any state: FSM->IDLE, busy_o=0 next cycle, no wb_o for the killed op.
  - A single-cycle op accepted the cycle before flush still writes back (it has already left the slot).
  - flush_i concurrent with enable_i: flush wins; slot dropped.
- Reset during MUL: abort, no writeback, all reset values.
- enable_i while busy_o=1: ignored (no queueing).

Optional Feature:
- EXEC_MUL_EN defined: multiplier FSM built as above.
- Not defined: OP_MUL treated as illegal opcode (wb_o=0); busy_o tied 0; FSM and accumulator absent.

Decomposition:
- Shared package (exec_pkg):
  - Opcodes: OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_SHL=6, OP_SHR=7, OP_MUL=8.
  - Function types: FT_ARITH=2'b00, FT_LS=2'b01.
  - Status bit indices: ST_CARRY=0, ST_ZERO=1.
  - FSM state encoding.
- One sub-module: exec_mul_iter (shift-add multiplier FSM with start/done/abort). Instanced only under EXEC_MUL_EN.

Test Plan:
- ADD prim=0xFFFF sec=0x0001 wb_i=1 reg=3 -> next cycle wb_o=1, wbAddr_o=3, wbVal_o=0x0000, status=2'b11.
- SUB prim=0x0005 sec=0x0007 -> wbVal_o=0xFFFE, carry=1, zero=0. SHL prim=0x0001 sec=0x0013 -> wbVal_o=0x0008 (shift uses sec[3:0]=3).
- MUL 0x0100 x 0x0100 reg=7 -> busy_o high 16 cycles; wb_o at cycle 17 with wbVal_o=0x0000, carry=1, zero=1. ADD issued during busy is ignored; ADD issued the cycle busy_o falls writes back 1 cycle later.
- MUL 0x0003 x 0x0005, flush_i asserted at cycle 5 -> no wb_o, busy_o=0 next cycle; following MUL gives 0x000F.
- functionType_i=FT_LS with enable_i=1, or OP_NOP with wb_i=1 -> wb_o stays 0, outputs hold.
- reset_i pulsed mid-MUL -> all outputs 0 next cycle, no wb_o. Build without EXEC_MUL_EN: OP_MUL -> wb_o=0, busy_o=0.
